// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from a level-handshake UART receiver stage
// into a first-word-fall-through FIFO read from the bus side.
// The receiver holds rx_data_available high until it sees a one-cycle
// rx_clear. A byte that arrives while the FIFO is full is dropped and the
// sticky overrun flag is raised.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int IRQ_LEVEL = 1
) (
  input  logic          clk_bus,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_data_available,
  output logic          rx_clear,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overrun,
  input  logic          ovr_clr,
  input  logic          flush,
  output logic          irq
);

  localparam logic [AW:0]   LP_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LP_IRQ_LEVEL = (AW+1)'(IRQ_LEVEL);
  localparam logic [AW:0]   LP_CNT_ZERO  = (AW+1)'(0);
  localparam logic [AW:0]   LP_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] LP_PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0] LP_PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_rx_clear;
  logic [7:0]    r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overrun;

  logic          w_capture;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // The byte is sampled only in IDLE, so ACK/HOLD can never capture twice.
  assign w_capture = (r_state == ST_IDLE) && rx_data_available;
  assign w_full    = (r_count == LP_DEPTH);
  assign w_pop     = rd_en && (r_count != LP_CNT_ZERO);
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_drop    = w_capture && w_full && !w_pop;

  // Capture FSM state register.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture FSM next-state: IDLE -> ACK on a byte, ACK -> HOLD, HOLD waits for the receiver to drop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_data_available) begin
          w_state_nxt = ST_ACK;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!rx_data_available) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // rx_clear is registered so it is high exactly while the FSM sits in ACK.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_clear <= 1'b0;
    end else begin
      r_rx_clear <= (w_state_nxt == ST_ACK);
    end
  end

  // Storage array; left unreset, a flushed push does not write.
  always_ff @(posedge clk_bus) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= rx_data;
    end
  end

  // Pointers and fill count; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= LP_PTR_ZERO;
      r_rd_ptr <= LP_PTR_ZERO;
      r_count  <= LP_CNT_ZERO;
    end else if (flush) begin
      r_wr_ptr <= LP_PTR_ZERO;
      r_rd_ptr <= LP_PTR_ZERO;
      r_count  <= LP_CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun: a dropped byte sets it and beats a same-cycle clear.
  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (ovr_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign rx_clear = r_rx_clear;
  assign rd_data  = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign empty    = (r_count == LP_CNT_ZERO);
  assign full     = w_full;
  assign overrun  = r_overrun;
  assign irq      = (r_count >= LP_IRQ_LEVEL) || r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, IRQ_LEVEL=1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_rx_fifo;

  logic       clk_bus = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_data_available;
  logic       rx_clear;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;
  logic       flush;
  logic       irq;

  int n_checks = 0;
  int n_errors = 0;
  int clr_pulses = 0;
  int base;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .IRQ_LEVEL(1)) dut (
    .clk_bus           (clk_bus),
    .rst_n             (rst_n),
    .rx_data           (rx_data),
    .rx_data_available (rx_data_available),
    .rx_clear          (rx_clear),
    .rd_en             (rd_en),
    .rd_data           (rd_data),
    .empty             (empty),
    .full              (full),
    .count             (count),
    .overrun           (overrun),
    .ovr_clr           (ovr_clr),
    .flush             (flush),
    .irq               (irq)
  );

  always #5 clk_bus = ~clk_bus;

  // Count rx_clear pulses as seen at the sampling edge.
  always @(negedge clk_bus) begin
    if (rx_clear === 1'b1) clr_pulses <= clr_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Receiver model: present a byte, wait for rx_clear, release, let FSM return to IDLE.
  task automatic send_byte(input logic [7:0] b, input logic do_pop, input logic do_flush);
    bit seen = 1'b0;
    rx_data = b;
    rx_data_available = 1'b1;
    rd_en = do_pop;
    flush = do_flush;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_bus);
      rd_en = 1'b0;
      flush = 1'b0;
      if (rx_clear === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("rx_clear_timeout", 32'd0, 32'd1);
    rx_data_available = 1'b0;
    @(negedge clk_bus);
    @(negedge clk_bus);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk(tag, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    @(negedge clk_bus);
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_data = 8'h00;
    rx_data_available = 1'b0;
    rd_en = 1'b0;
    ovr_clr = 1'b0;
    flush = 1'b0;
    repeat (3) @(negedge clk_bus);

    // Reset state
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rx_clear", {31'd0, rx_clear}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk_bus);

    // Single byte
    base = clr_pulses;
    send_byte(8'h5A, 1'b0, 1'b0);
    chk("single_pulses", clr_pulses - base, 32'd1);
    chk("single_count", {27'd0, count}, 32'd1);
    chk("single_empty", {31'd0, empty}, 32'd0);
    chk("single_irq", {31'd0, irq}, 32'd1);
    pop_check("single_data", 8'h5A);
    chk("single_count_after_pop", {27'd0, count}, 32'd0);

    // Fill, partial drain, refill across the wrap, full drain
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0, 1'b0);
    chk("fill_count16", {27'd0, count}, 32'd16);
    chk("fill_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check("fill_pop_a", 8'(i));
    chk("fill_count12", {27'd0, count}, 32'd12);
    for (int i = 16; i < 20; i++) send_byte(8'(i), 1'b0, 1'b0);
    chk("fill_count_refill", {27'd0, count}, 32'd16);
    chk("fill_no_overrun", {31'd0, overrun}, 32'd0);
    for (int i = 4; i < 20; i++) pop_check("fill_pop_b", 8'(i));
    chk("fill_drained", {27'd0, count}, 32'd0);
    chk("fill_empty", {31'd0, empty}, 32'd1);

    // Pop while empty is ignored
    rd_en = 1'b1;
    @(negedge clk_bus);
    rd_en = 1'b0;
    chk("empty_pop_count", {27'd0, count}, 32'd0);
    chk("empty_pop_empty", {31'd0, empty}, 32'd1);

    // Overrun: 17 bytes, last one dropped
    base = clr_pulses;
    for (int i = 0; i < 17; i++) send_byte(8'h30 + 8'(i), 1'b0, 1'b0);
    chk("ovr_pulses", clr_pulses - base, 32'd17);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    chk("ovr_full", {31'd0, full}, 32'd1);
    chk("ovr_count", {27'd0, count}, 32'd16);
    ovr_clr = 1'b1;
    @(negedge clk_bus);
    ovr_clr = 1'b0;
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);

    // Full with simultaneous push and pop
    chk("fullpp_head", {24'd0, rd_data}, 32'h30);
    send_byte(8'hAA, 1'b1, 1'b0);
    chk("fullpp_count", {27'd0, count}, 32'd16);
    chk("fullpp_overrun", {31'd0, overrun}, 32'd0);
    for (int i = 1; i < 16; i++) pop_check("fullpp_pop", 8'h30 + 8'(i));
    pop_check("fullpp_last", 8'hAA);
    chk("fullpp_empty", {31'd0, empty}, 32'd1);

    // Flush colliding with a push
    for (int i = 0; i < 3; i++) send_byte(8'h60 + 8'(i), 1'b0, 1'b0);
    chk("flush_pre_count", {27'd0, count}, 32'd3);
    base = clr_pulses;
    send_byte(8'h99, 1'b0, 1'b1);
    chk("flush_count", {27'd0, count}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    chk("flush_pulses", clr_pulses - base, 32'd1);
    send_byte(8'h77, 1'b0, 1'b0);
    chk("flush_next_count", {27'd0, count}, 32'd1);
    pop_check("flush_next_data", 8'h77);

    // Reset in ACK, byte still held, must be captured exactly once afterwards
    rx_data = 8'hC3;
    rx_data_available = 1'b1;
    @(negedge clk_bus);
    chk("rstack_in_ack", {31'd0, rx_clear}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstack_rx_clear", {31'd0, rx_clear}, 32'd0);
    chk("rstack_count0", {27'd0, count}, 32'd0);
    @(negedge clk_bus);
    @(negedge clk_bus);
    rst_n = 1'b1;
    @(negedge clk_bus);
    chk("rstack_recapture", {27'd0, count}, 32'd1);
    chk("rstack_ack", {31'd0, rx_clear}, 32'd1);
    rx_data_available = 1'b0;
    repeat (3) @(negedge clk_bus);
    chk("rstack_once", {27'd0, count}, 32'd1);
    chk("rstack_data", {24'd0, rd_data}, 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
